// File: rtl/cva6_clic_irq_arbiter.sv
// CLIC-to-CVA6 interrupt arbiter: filters the CLIC's selected irq against privilege, enables and
// thresholds, then holds it as a registered request through IDLE/REQ/ACK. Optional: CLIC_UMODE_EN.
module cva6_clic_irq_arbiter #(
  parameter int unsigned NumSrc = 256,
  parameter int unsigned LvlW   = 8,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned IdW    = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic            mie_i,
  input  logic            sie_i,
  input  logic            uie_i,
  input  logic [LvlW-1:0] mintthresh_i,
  input  logic [LvlW-1:0] sintthresh_i,
  input  logic [LvlW-1:0] uintthresh_i,
  input  logic [LvlW-1:0] mil_i,
  input  logic [LvlW-1:0] sil_i,
  input  logic [LvlW-1:0] uil_i,
  input  logic            clic_irq_valid_i,
  input  logic [IdW-1:0]  clic_irq_id_i,
  input  logic [LvlW-1:0] clic_irq_level_i,
  input  logic [1:0]      clic_irq_priv_i,
  output logic            clic_irq_ready_o,
  input  logic            kill_req_i,
  output logic            kill_ack_o,
  output logic            irq_req_o,
  output logic [1:0]      irq_priv_o,
  output logic [LvlW-1:0] irq_level_o,
  output logic [XLEN-1:0] irq_cause_o,
  input  logic            irq_ack_i
);

  localparam logic [1:0] PrivM = 2'd3;
  localparam logic [1:0] PrivS = 2'd1;
  localparam logic [1:0] PrivU = 2'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              capture;
  logic              hit;
  logic              u_hit;
  logic [LvlW-1:0]   m_th, s_th;
  logic [IdW-1:0]    id_q;
  logic [LvlW-1:0]   level_q;
  logic [1:0]        priv_q;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic              req_q, ready_q;

  // Effective threshold is the stricter of the programmed threshold and the current level.
  assign m_th = (mintthresh_i > mil_i) ? mintthresh_i : mil_i;
  assign s_th = (sintthresh_i > sil_i) ? sintthresh_i : sil_i;

`ifdef CLIC_UMODE_EN
  logic [LvlW-1:0] u_th;
  assign u_th  = (uintthresh_i > uil_i) ? uintthresh_i : uil_i;
  assign u_hit = (clic_irq_priv_i == PrivU) && (clic_irq_level_i > u_th) && uie_i;
`else
  logic unused_umode;
  assign unused_umode = ^{uie_i, uintthresh_i, uil_i};
  assign u_hit        = 1'b0;
`endif

  // An irq targeting a higher privilege than the current mode is taken regardless of that
  // mode's enable and threshold; same-privilege irqs need both.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hit = 1'b0;
    if (clic_irq_valid_i) begin
      case (priv_lvl_i)
        PrivM: hit = (clic_irq_priv_i == PrivM) && (clic_irq_level_i > m_th) && mie_i;
        PrivS: hit = (clic_irq_priv_i == PrivM)
                  || ((clic_irq_priv_i == PrivS) && (clic_irq_level_i > s_th) && sie_i);
        PrivU: hit = (clic_irq_priv_i == PrivM)
                  || ((clic_irq_priv_i == PrivS) && sie_i)
                  || u_hit;
        default: hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    kill_ack_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (kill_req_i) begin
          kill_ack_o = 1'b1;
        end else if (hit) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // A committed trap outranks a withdrawal; the kill is acknowledged from ACK instead.
        if (irq_ack_i) begin
          state_d = ACK;
        end else if (kill_req_i) begin
          kill_ack_o = 1'b1;
          state_d    = IDLE;
        end else if (!hit) begin
          state_d = IDLE;
        end else if (clic_irq_level_i > level_q) begin
          capture = 1'b1;
        end
      end
      ACK: begin
        kill_ack_o = kill_req_i;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cause_d                = '0;
    cause_d[XLEN-1]        = 1'b1;
    cause_d[16 +: LvlW]    = clic_irq_level_i;
    cause_d[IdW-1:0]       = clic_irq_id_i;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values,
    // independent of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == REQ);
      ready_q <= (state_d == ACK);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the capture registers are reset too, so the held id/level/cause read as zero
    // after reset rather than whatever the last request left behind.
    if (rst_i) begin
      id_q    <= '0;
      level_q <= '0;
      priv_q  <= '0;
      cause_q <= '0;
    end else if (capture) begin
      id_q    <= clic_irq_id_i;
      level_q <= clic_irq_level_i;
      priv_q  <= clic_irq_priv_i;
      cause_q <= cause_d;
    end
  end

  logic unused_id;
  assign unused_id = ^id_q;

  assign irq_req_o        = req_q;
  assign clic_irq_ready_o = ready_q;
  assign irq_priv_o       = priv_q;
  assign irq_level_o      = level_q;
  assign irq_cause_o      = cause_q;

endmodule

// File: tb/tb_cva6_clic_irq_arbiter.sv
// Directed bench for cva6_clic_irq_arbiter: expected outputs are queued as each step is driven
// and popped after the clock edge; kill_ack_o is checked combinationally.
module tb_cva6_clic_irq_arbiter;

  localparam int unsigned LvlW = 8;
  localparam int unsigned IdW  = 8;
  localparam int unsigned XLEN = 64;
  localparam logic [1:0] PM = 2'd3, PS = 2'd1, PU = 2'd0, PR = 2'd2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [1:0] priv_lvl_i;
  logic mie_i, sie_i, uie_i;
  logic [LvlW-1:0] mintthresh_i, sintthresh_i, uintthresh_i, mil_i, sil_i, uil_i;
  logic clic_irq_valid_i;
  logic [IdW-1:0] clic_irq_id_i;
  logic [LvlW-1:0] clic_irq_level_i;
  logic [1:0] clic_irq_priv_i;
  logic clic_irq_ready_o, kill_req_i, kill_ack_o, irq_req_o, irq_ack_i;
  logic [1:0] irq_priv_o;
  logic [LvlW-1:0] irq_level_o;
  logic [XLEN-1:0] irq_cause_o;

  typedef struct {
    string           tag;
    logic            req;
    logic            ready;
    logic [1:0]      priv;
    logic [LvlW-1:0] lvl;
    logic [XLEN-1:0] cause;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  cva6_clic_irq_arbiter #(.NumSrc(256), .LvlW(LvlW), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .priv_lvl_i(priv_lvl_i),
    .mie_i(mie_i), .sie_i(sie_i), .uie_i(uie_i),
    .mintthresh_i(mintthresh_i), .sintthresh_i(sintthresh_i), .uintthresh_i(uintthresh_i),
    .mil_i(mil_i), .sil_i(sil_i), .uil_i(uil_i),
    .clic_irq_valid_i(clic_irq_valid_i), .clic_irq_id_i(clic_irq_id_i),
    .clic_irq_level_i(clic_irq_level_i), .clic_irq_priv_i(clic_irq_priv_i),
    .clic_irq_ready_o(clic_irq_ready_o), .kill_req_i(kill_req_i), .kill_ack_o(kill_ack_o),
    .irq_req_o(irq_req_o), .irq_priv_o(irq_priv_o), .irq_level_o(irq_level_o),
    .irq_cause_o(irq_cause_o), .irq_ack_i(irq_ack_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_irq(input logic v, input logic [1:0] pr, input logic [7:0] lv,
                         input logic [7:0] id);
    clic_irq_valid_i = v;
    clic_irq_priv_i  = pr;
    clic_irq_level_i = lv;
    clic_irq_id_i    = id;
  endtask

  task automatic check_kill(input string tag, input logic exp);
    #1;
    check({tag, ".kill_ack"}, XLEN'(kill_ack_o), XLEN'(exp));
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic req, input logic rdy, input logic [1:0] pr,
                      input logic [7:0] lv, input logic [7:0] id, input logic cap);
    exp_t e;
    exp_t got;
    e.tag   = tag;
    e.req   = req;
    e.ready = rdy;
    e.priv  = pr;
    e.lvl   = lv;
    e.cause = cap ? ((XLEN'(1) << (XLEN-1)) | (XLEN'(lv) << 16) | XLEN'(id)) : '0;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    check({got.tag, ".req"},   XLEN'(irq_req_o),        XLEN'(got.req));
    check({got.tag, ".ready"}, XLEN'(clic_irq_ready_o), XLEN'(got.ready));
    check({got.tag, ".priv"},  XLEN'(irq_priv_o),       XLEN'(got.priv));
    check({got.tag, ".level"}, XLEN'(irq_level_o),      XLEN'(got.lvl));
    check({got.tag, ".cause"}, irq_cause_o,             got.cause);
  endtask

  initial begin
    rst_i = 1'b1;
    priv_lvl_i = PM;
    mie_i = 1'b0; sie_i = 1'b0; uie_i = 1'b0;
    mintthresh_i = '0; sintthresh_i = '0; uintthresh_i = '0;
    mil_i = '0; sil_i = '0; uil_i = '0;
    kill_req_i = 1'b0; irq_ack_i = 1'b0;
    set_irq(1'b0, PU, 8'd0, 8'd0);

    step("reset", 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    check_kill("reset", 1'b0);
    rst_i = 1'b0;

    // Strict threshold in M mode: level equal to max(mth, mil) does not hit.
    mie_i = 1'b1; mintthresh_i = 8'd3; mil_i = 8'd5;
    set_irq(1'b1, PM, 8'd5, 8'd3);
    step("m_equal_th", 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    set_irq(1'b1, PM, 8'd6, 8'd7);
    step("m_hit", 1'b1, 1'b0, PM, 8'd6, 8'd7, 1'b1);

    // Core acknowledges: one-cycle ready pulse, then idle.
    irq_ack_i = 1'b1;
    step("ack", 1'b0, 1'b1, PM, 8'd6, 8'd7, 1'b1);
    irq_ack_i = 1'b0;
    set_irq(1'b0, PM, 8'd0, 8'd0);
    step("ack_done", 1'b0, 1'b0, PM, 8'd6, 8'd7, 1'b1);

    // Replacement by strictly higher level only.
    mil_i = 8'd0;
    set_irq(1'b1, PM, 8'd4, 8'd1);
    step("req_l4", 1'b1, 1'b0, PM, 8'd4, 8'd1, 1'b1);
    set_irq(1'b1, PM, 8'd9, 8'd12);
    step("replace_l9", 1'b1, 1'b0, PM, 8'd9, 8'd12, 1'b1);
    set_irq(1'b1, PM, 8'd4, 8'd2);
    step("lower_ignored", 1'b1, 1'b0, PM, 8'd9, 8'd12, 1'b1);
    set_irq(1'b1, PM, 8'd9, 8'd13);
    step("equal_ignored", 1'b1, 1'b0, PM, 8'd9, 8'd12, 1'b1);

    // Ack beats kill; kill is acknowledged from ACK.
    kill_req_i = 1'b1; irq_ack_i = 1'b1;
    check_kill("ack_vs_kill", 1'b0);
    step("ack_vs_kill", 1'b0, 1'b1, PM, 8'd9, 8'd12, 1'b1);
    irq_ack_i = 1'b0;
    check_kill("kill_in_ack", 1'b1);
    kill_req_i = 1'b0;
    set_irq(1'b0, PM, 8'd0, 8'd0);
    step("after_ack", 1'b0, 1'b0, PM, 8'd9, 8'd12, 1'b1);

    // Kill in IDLE beats a hit; kill in REQ withdraws.
    set_irq(1'b1, PM, 8'd5, 8'd20);
    kill_req_i = 1'b1;
    check_kill("kill_idle", 1'b1);
    step("kill_idle", 1'b0, 1'b0, PM, 8'd9, 8'd12, 1'b1);
    kill_req_i = 1'b0;
    step("req_after_kill", 1'b1, 1'b0, PM, 8'd5, 8'd20, 1'b1);
    kill_req_i = 1'b1;
    check_kill("kill_req", 1'b1);
    step("kill_req", 1'b0, 1'b0, PM, 8'd5, 8'd20, 1'b1);
    kill_req_i = 1'b0;
    set_irq(1'b1, PM, 8'd6, 8'd21);
    step("req_l6", 1'b1, 1'b0, PM, 8'd6, 8'd21, 1'b1);
    set_irq(1'b0, PM, 8'd6, 8'd21);
    check_kill("withdraw", 1'b0);
    step("withdraw", 1'b0, 1'b0, PM, 8'd6, 8'd21, 1'b1);

    // S mode: disabled S irq ignored even at max level; M irq always taken.
    priv_lvl_i = PS; sie_i = 1'b0;
    set_irq(1'b1, PS, 8'd255, 8'd30);
    step("s_disabled", 1'b0, 1'b0, PM, 8'd6, 8'd21, 1'b1);
    set_irq(1'b1, PM, 8'd0, 8'd31);
    step("s_mode_m_irq", 1'b1, 1'b0, PM, 8'd0, 8'd31, 1'b1);
    set_irq(1'b0, PM, 8'd0, 8'd0);
    step("s_withdraw", 1'b0, 1'b0, PM, 8'd0, 8'd31, 1'b1);

    // Reserved privilege never hits.
    priv_lvl_i = PR;
    set_irq(1'b1, PM, 8'd200, 8'd33);
    step("priv_reserved", 1'b0, 1'b0, PM, 8'd0, 8'd31, 1'b1);

    // U mode, U-target irq: taken only with U-mode support.
    priv_lvl_i = PU; uie_i = 1'b1; uintthresh_i = 8'd1; uil_i = 8'd0;
    set_irq(1'b1, PU, 8'd3, 8'd40);
`ifdef CLIC_UMODE_EN
    step("u_irq", 1'b1, 1'b0, PU, 8'd3, 8'd40, 1'b1);
    set_irq(1'b0, PU, 8'd0, 8'd0);
    step("u_withdraw", 1'b0, 1'b0, PU, 8'd3, 8'd40, 1'b1);
`else
    step("u_irq", 1'b0, 1'b0, PM, 8'd0, 8'd31, 1'b1);
    set_irq(1'b0, PU, 8'd0, 8'd0);
`endif

    // Reset mid-request drops it silently and clears held fields.
    set_irq(1'b1, PM, 8'd1, 8'd50);
    step("u_mode_m_irq", 1'b1, 1'b0, PM, 8'd1, 8'd50, 1'b1);
    rst_i = 1'b1;
    step("reset_mid_req", 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    rst_i = 1'b0;
    set_irq(1'b0, PU, 8'd0, 8'd0);
    step("post_reset", 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
